// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: FSM encoding and parameter defaults.
package period_meter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ARM     = 2'd1;
  localparam state_t ST_MEASURE = 2'd2;

  localparam int unsigned CNT_W_DEF   = 27;
  localparam int unsigned TIMEOUT_DEF = 100_000_000;

endpackage

// File: rtl/period_meter_sync_edge_detect.sv
// Multi-stage synchronizer for an asynchronous input plus rise/fall detection.
// Reusable for button lines and other slow external signals.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic sysclk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_sync    <= '0;
      r_level_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], d};
      r_level_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign level = r_sync[SYNC_STAGES-1];
  assign rise  = level & ~r_level_d;
  assign fall  = ~level & r_level_d;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous signal in sysclk cycles,
// publishing results with a one-cycle valid pulse and flagging a stalled input.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_valid;
  logic             r_timeout;

  logic w_level;
  logic w_rise;
  logic w_fall;
  logic w_unused_level;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .sysclk(sysclk),
    .reset (reset),
    .d     (sig_in),
    .level (w_level),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  // Only the edges matter here; the synchronized level is deliberately dropped.
  assign w_unused_level = w_level;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (enable) r_state <= ST_ARM;
        end

        ST_ARM: begin
          if (!enable) begin
            r_state <= ST_IDLE;
          end else if (w_rise) begin
            r_cnt   <= ONE;
            r_state <= ST_MEASURE;
          end
        end

        ST_MEASURE: begin
          if (!enable) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            if (w_fall) r_high <= r_cnt;
            // A rise wins over the timeout, so period == TIMEOUT is a legal result.
            // Leaving MEASURE at TMO is what keeps the counter from wrapping.
            if (w_rise) begin
              r_period  <= r_cnt;
              r_cnt     <= ONE;
              r_valid   <= 1'b1;
              r_timeout <= 1'b0;
            end else if (r_cnt == TMO) begin
              r_timeout <= 1'b1;
              r_cnt     <= '0;
              r_state   <= ST_ARM;
            end else begin
              r_cnt <= r_cnt + ONE;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign period    = r_period;
  assign high_time = r_high;
  assign valid     = r_valid;
  assign timeout   = r_timeout;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: square waves, timeout, enable drop, reset, boundary period.
module tb_period_meter;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 20;

  logic             sysclk;
  logic             reset;
  logic             enable;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             timeout;
  logic             busy;

  int errors;
  int checks;

  int cyc;
  int n_valid;
  int n_tmo;
  int n_busy_low;
  int first_valid_cyc;
  int first_tmo_cyc;
  int wave_start;
  logic chk_vals;
  int exp_p;
  int exp_h;

  period_meter #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(2)
  ) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .enable   (enable),
    .sig_in   (sig_in),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .timeout  (timeout),
    .busy     (busy)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic clr();
    n_valid         = 0;
    n_tmo           = 0;
    n_busy_low      = 0;
    first_valid_cyc = -1;
    first_tmo_cyc   = -1;
  endtask

  // Drive one cycle of sig_in and observe outputs on the following falling edge.
  task automatic tick(input logic v);
    sig_in = v;
    @(posedge sysclk);
    @(negedge sysclk);
    cyc++;
    if (valid) begin
      n_valid++;
      if (n_valid == 1) first_valid_cyc = cyc;
      if (chk_vals) begin
        check("period_at_valid", int'(period), exp_p);
        check("high_time_at_valid", int'(high_time), exp_h);
        check("timeout_at_valid", int'(timeout), 0);
      end
    end
    if (!busy) n_busy_low++;
    if (timeout) begin
      n_tmo++;
      if (n_tmo == 1) first_tmo_cyc = cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  task automatic wave(input int h, input int l, input int n);
    wave_start = cyc + 1;
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < h; i++) tick(1'b1);
      for (int i = 0; i < l; i++) tick(1'b0);
    end
  endtask

  task automatic restart();
    enable = 1'b0;
    idle(2);
    enable = 1'b1;
    idle(2);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    cyc      = 0;
    chk_vals = 1'b1;
    exp_p    = 0;
    exp_h    = 0;
    clr();
    reset  = 1'b0;
    enable = 1'b0;
    sig_in = 1'b0;

    #1;
    check("rst_period", int'(period), 0);
    check("rst_high_time", int'(high_time), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge sysclk);
    @(negedge sysclk);
    reset = 1'b1;
    idle(2);
    check("idle_busy", int'(busy), 0);

    // 2 high / 2 low: six rises give five measurements.
    enable = 1'b1;
    idle(3);
    clr();
    exp_p = 4;
    exp_h = 2;
    wave(2, 2, 6);
    idle(4);
    check("sq4_valid_count", n_valid, 5);
    check("sq4_first_valid_delay", first_valid_cyc - wave_start, 4 + 2);
    check("sq4_timeout_seen", n_tmo, 0);
    check("sq4_busy_low", n_busy_low, 0);

    // 3 high / 7 low, five periods.
    restart();
    clr();
    exp_p = 10;
    exp_h = 3;
    wave(3, 7, 5);
    check("p10_valid_count", n_valid, 4);
    check("p10_busy_low", n_busy_low, 0);
    check("p10_timeout_seen", n_tmo, 0);

    // Period 12, then enable dropped mid-period and re-enabled.
    restart();
    clr();
    exp_p = 12;
    exp_h = 4;
    wave(4, 8, 3);
    check("p12_valid_count", n_valid, 2);
    enable = 1'b0;
    clr();
    wave(4, 8, 2);
    check("dis_valid_count", n_valid, 0);
    check("dis_busy_low", n_busy_low, 24);
    check("dis_period_held", int'(period), 12);
    check("dis_high_held", int'(high_time), 4);
    enable = 1'b1;
    idle(2);
    clr();
    wave(4, 8, 2);
    check("reen_valid_count", n_valid, 1);
    check("reen_first_valid_delay", first_valid_cyc - wave_start, 12 + 2);

    // Timeout: one rise then a stalled line.
    restart();
    clr();
    exp_p = 8;
    exp_h = 4;
    wave(3, 25, 1);
    check("tmo_delay", first_tmo_cyc - wave_start, TIMEOUT + 2);
    check("tmo_no_valid", n_valid, 0);
    check("tmo_flag", int'(timeout), 1);
    check("tmo_busy_arm", int'(busy), 1);
    check("tmo_period_held", int'(period), 12);
    clr();
    wave(4, 4, 2);
    idle(3);
    check("tmo_recover_valid", n_valid, 1);
    check("tmo_cleared", int'(timeout), 0);

    // Rise landing exactly on cnt == TIMEOUT.
    restart();
    clr();
    exp_p = 20;
    exp_h = 5;
    wave(5, 15, 2);
    enable = 1'b0;
    idle(1);
    check("edge_valid_count", n_valid, 1);
    check("edge_timeout_seen", n_tmo, 0);
    check("edge_busy_low", n_busy_low, 1);

    // Asynchronous reset mid-MEASURE, then restart from ARM.
    enable = 1'b1;
    idle(2);
    clr();
    exp_p = 10;
    exp_h = 3;
    wave(3, 7, 2);
    tick(1'b1);
    tick(1'b1);
    check("pre_rst_period", int'(period), 10);
    check("pre_rst_busy", int'(busy), 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_period", int'(period), 0);
    check("arst_high_time", int'(high_time), 0);
    check("arst_valid", int'(valid), 0);
    check("arst_timeout", int'(timeout), 0);
    check("arst_busy", int'(busy), 0);
    @(negedge sysclk);
    idle(2);
    reset = 1'b1;
    clr();
    tick(1'b0);
    check("post_rst_busy", int'(busy), 1);
    check("post_rst_period", int'(period), 0);
    tick(1'b0);
    wave(3, 7, 2);
    idle(3);
    check("post_rst_valid_count", n_valid, 1);
    check("post_rst_first_valid_delay", first_valid_cyc - wave_start, 10 + 2);

    enable = 1'b0;
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
